// File: rtl/aha_async_pulse_send.sv
// aha_async_pulse_send
// Source-domain half of a two-phase toggle crossing. Each PULSE_IN becomes one
// inversion of REQ_TOGGLE; further toggles are held back until the synchronised
// ACK_TOGGLE matches REQ_TOGGLE. Pulses that arrive while a handshake is
// outstanding are counted in PENDING and replayed one per handshake.
// Optional feature: define AHA_PULSE_SEND_OVF_STICKY_EN to make OVERFLOW sticky
// (cleared by CLR_OVF). Without it OVERFLOW is a one-cycle pulse per dropped
// pulse and CLR_OVF is ignored.
// SYNC_STAGES must be at least 2.

module aha_async_pulse_send #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             PULSE_IN,
    input  logic             ACK_TOGGLE,
    input  logic             CLR_OVF,
    output logic             REQ_TOGGLE,
    output logic             BUSY,
    output logic [CNT_W-1:0] PENDING,
    output logic             OVERFLOW
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    state_t                 state;
    state_t                 state_nxt;
    logic                   req_nxt;
    logic [CNT_W-1:0]       pending_nxt;
    logic                   ovf_event;
    logic                   ovf_nxt;
    logic                   launch;
    logic [SYNC_STAGES-1:0] ack_chain;
    logic                   ack_sync;
    logic                   done;

    // Bring the asynchronous acknowledge level into the CLK domain
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ack_chain <= '0;
        end else begin
            ack_chain <= {ack_chain[SYNC_STAGES-2:0], ACK_TOGGLE};
        end
    end

    assign ack_sync = ack_chain[SYNC_STAGES-1];
    assign done     = (ack_sync == REQ_TOGGLE);

    // Handshake sequencing and pending-pulse bookkeeping
    always_comb begin
        state_nxt   = state;
        req_nxt     = REQ_TOGGLE;
        pending_nxt = PENDING;
        ovf_event   = 1'b0;
        launch      = 1'b0;
        case (state)
            IDLE: begin
                launch = PULSE_IN | (PENDING != '0);
                if (launch) begin
                    req_nxt   = ~REQ_TOGGLE;
                    state_nxt = WAIT;
                    // A new pulse is consumed by this launch; otherwise a queued one is
                    if (!PULSE_IN) begin
                        pending_nxt = PENDING - CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (PULSE_IN) begin
                    if (PENDING == MAX) begin
                        ovf_event = 1'b1;
                    end else begin
                        pending_nxt = PENDING + CNT_W'(1);
                    end
                end
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef AHA_PULSE_SEND_OVF_STICKY_EN
    // A new drop sets the flag even when a clear is requested in the same cycle
    assign ovf_nxt = ovf_event ? 1'b1 : (CLR_OVF ? 1'b0 : OVERFLOW);
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = CLR_OVF;
    assign ovf_nxt        = ovf_event;
`endif

    // State, toggle, counter and status registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= IDLE;
            REQ_TOGGLE <= 1'b0;
            PENDING    <= '0;
            BUSY       <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            state      <= state_nxt;
            REQ_TOGGLE <= req_nxt;
            PENDING    <= pending_nxt;
            BUSY       <= (state_nxt == WAIT);
            OVERFLOW   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_aha_async_pulse_send.sv
// tb_aha_async_pulse_send
// Directed bench for aha_async_pulse_send with CNT_W=4, SYNC_STAGES=2.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_aha_async_pulse_send;

`ifdef AHA_PULSE_SEND_OVF_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       PULSE_IN = 1'b0;
    logic       ACK_TOGGLE = 1'b0;
    logic       CLR_OVF = 1'b0;
    logic       REQ_TOGGLE;
    logic       BUSY;
    logic [3:0] PENDING;
    logic       OVERFLOW;

    int   testsRun = 0;
    int   testsFailed = 0;
    logic expReq;

    aha_async_pulse_send #(.CNT_W(4), .SYNC_STAGES(2)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .PULSE_IN   (PULSE_IN),
        .ACK_TOGGLE (ACK_TOGGLE),
        .CLR_OVF    (CLR_OVF),
        .REQ_TOGGLE (REQ_TOGGLE),
        .BUSY       (BUSY),
        .PENDING    (PENDING),
        .OVERFLOW   (OVERFLOW)
    );

    // Free-running source clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pulse, input logic ack, input logic clr);
        PULSE_IN   = pulse;
        ACK_TOGGLE = ack;
        CLR_OVF    = clr;
        @(negedge CLK);
    endtask

    task automatic doReset();
        RESETn     = 1'b0;
        PULSE_IN   = 1'b0;
        ACK_TOGGLE = 1'b0;
        CLR_OVF    = 1'b0;
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        expReq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        expReq = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("reset_req", 8'(REQ_TOGGLE), 8'd0);
        checkOutput("reset_busy", 8'(BUSY), 8'd0);
        checkOutput("reset_pending", 8'(PENDING), 8'd0);
        checkOutput("reset_ovf", 8'(OVERFLOW), 8'd0);
        RESETn = 1'b1;

        // Single pulse, acknowledge returned a few cycles later
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s1_req", 8'(REQ_TOGGLE), 8'd1);
        checkOutput("s1_busy", 8'(BUSY), 8'd1);
        checkOutput("s1_pending", 8'(PENDING), 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s1_busy_noack", 8'(BUSY), 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("s1_busy_sync1", 8'(BUSY), 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("s1_busy_sync2", 8'(BUSY), 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("s1_busy_done", 8'(BUSY), 8'd0);
        checkOutput("s1_req_hold", 8'(REQ_TOGGLE), 8'd1);
        checkOutput("s1_pending_end", 8'(PENDING), 8'd0);

        // Spurious acknowledge change while idle is ignored
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s6_req", 8'(REQ_TOGGLE), 8'd1);
        checkOutput("s6_busy", 8'(BUSY), 8'd0);
        checkOutput("s6_pending", 8'(PENDING), 8'd0);

        // Five back-to-back pulses replayed one per handshake
        doReset();
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        expReq = 1'b1;
        checkOutput("s2_req_first", 8'(REQ_TOGGLE), 8'(expReq));
        checkOutput("s2_pending4", 8'(PENDING), 8'd4);
        checkOutput("s2_busy", 8'(BUSY), 8'd1);
        for (int k = 3; k >= 0; k--) begin
            repeat (3) applyStimulus(1'b0, expReq, 1'b0);
            checkOutput("s2_gap_idle", 8'(BUSY), 8'd0);
            checkOutput("s2_gap_pending", 8'(PENDING), 8'(k + 1));
            applyStimulus(1'b0, expReq, 1'b0);
            expReq = ~expReq;
            checkOutput("s2_replay_req", 8'(REQ_TOGGLE), 8'(expReq));
            checkOutput("s2_replay_pending", 8'(PENDING), 8'(k));
            checkOutput("s2_replay_busy", 8'(BUSY), 8'd1);
        end
        repeat (3) applyStimulus(1'b0, expReq, 1'b0);
        checkOutput("s2_final_req", 8'(REQ_TOGGLE), 8'd1);
        checkOutput("s2_final_busy", 8'(BUSY), 8'd0);

        // Pulse coincident with done while two pulses are queued
        doReset();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s4_pending2", 8'(PENDING), 8'd2);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("s4_busy_presync", 8'(BUSY), 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("s4_pending3", 8'(PENDING), 8'd3);
        checkOutput("s4_idle", 8'(BUSY), 8'd0);
        checkOutput("s4_req_hold", 8'(REQ_TOGGLE), 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("s4_launch_req", 8'(REQ_TOGGLE), 8'd0);
        checkOutput("s4_launch_pending", 8'(PENDING), 8'd2);
        checkOutput("s4_launch_busy", 8'(BUSY), 8'd1);

        // Saturation and overflow reporting
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s3_pending_full", 8'(PENDING), 8'd15);
        checkOutput("s3_ovf_before", 8'(OVERFLOW), 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s3_pending_sat", 8'(PENDING), 8'd15);
        checkOutput("s3_ovf_drop", 8'(OVERFLOW), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s3_ovf_after", 8'(OVERFLOW), 8'(STICKY));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("s3_ovf_clr", 8'(OVERFLOW), 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("s3_ovf_setwins", 8'(OVERFLOW), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s3_ovf_hold", 8'(OVERFLOW), 8'(STICKY));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("s3_ovf_clr2", 8'(OVERFLOW), 8'd0);
        checkOutput("s3_busy", 8'(BUSY), 8'd1);
        checkOutput("s3_pending_end", 8'(PENDING), 8'd15);

        // Asynchronous reset in the middle of a handshake
        doReset();
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
        PULSE_IN = 1'b0;
        checkOutput("s5_pending7", 8'(PENDING), 8'd7);
        checkOutput("s5_req_pre", 8'(REQ_TOGGLE), 8'd1);
        #2;
        RESETn = 1'b0;
        #1;
        checkOutput("s5_async_req", 8'(REQ_TOGGLE), 8'd0);
        checkOutput("s5_async_busy", 8'(BUSY), 8'd0);
        checkOutput("s5_async_pending", 8'(PENDING), 8'd0);
        checkOutput("s5_async_ovf", 8'(OVERFLOW), 8'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s5_post_req", 8'(REQ_TOGGLE), 8'd0);
        checkOutput("s5_post_busy", 8'(BUSY), 8'd0);
        checkOutput("s5_post_pending", 8'(PENDING), 8'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
